// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: instruction fields, type codes, NOP constant, FSM states.
package mem_wb_stage_pkg;

  localparam int TYPE_HI = 7;
  localparam int TYPE_LO = 6;
  localparam int WREG_HI = 5;
  localparam int WREG_LO = 4;
  localparam int REG1_HI = 3;
  localparam int REG2_LO = 0;

  localparam logic [1:0] TYPE_ALU   = 2'b00;
  localparam logic [1:0] TYPE_LOAD  = 2'b01;
  localparam logic [1:0] TYPE_STORE = 2'b10;
  localparam logic [1:0] TYPE_NOP   = 2'b11;

  localparam logic [7:0] NOP_INST = 8'hC0;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;

  function automatic logic [1:0] inst_type(input logic [7:0] inst);
    return inst[TYPE_HI:TYPE_LO];
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// Private data memory: one synchronous write port, asynchronous read; write lands on the clock edge.
// No reset on the array; the stage's clear sequencer zeroes it after every reset.
module data_mem #(
  parameter int DATA_W   = 8,
  parameter int DM_DEPTH = 16,
  localparam int AW      = $clog2(DM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: loads/stores, registered write-back triple and retire counter; 1-cycle latency, no back-pressure.
// Define MEM_WB_BYPASS_EN to add combinational fwd_* forwarding of the current input slot to decode.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int INST_W   = 8,
  parameter int DM_DEPTH = 16
) (
  input  logic              clk,
  input  logic              mem_reset,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_store,
  output logic              busy,
  output logic              rf_we,
  output logic [1:0]        wreg,
  output logic [DATA_W-1:0] wdata,
  output logic [INST_W-1:0] wb_inst,
  output logic [7:0]        retired
`ifdef MEM_WB_BYPASS_EN
  ,
  output logic              fwd_valid,
  output logic [1:0]        fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int AW = $clog2(DM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DM_DEPTH - 1);

  state_t            state;
  logic [AW-1:0]     clr_addr;
  logic [AW-1:0]     addr;
  logic [1:0]        ityp;
  logic              accept;
  logic              dm_we;
  logic [AW-1:0]     dm_waddr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;

  // Upper address bits alias onto the low ones; reg1/reg2 are consumed upstream.
  logic unused_bits;
  assign unused_bits = ^{in_result[DATA_W-1:AW], in_inst[REG1_HI:REG2_LO]};

  assign addr   = in_result[AW-1:0];
  assign ityp   = inst_type(in_inst[7:0]);
  assign accept = (state == ST_RUN) && in_valid;
  assign busy   = (state == ST_CLEAR);

  always_comb begin
    dm_we    = 1'b0;
    dm_waddr = addr;
    dm_wdata = in_store;
    if (!mem_reset) begin
      if (state == ST_CLEAR) begin
        dm_we    = 1'b1;
        dm_waddr = clr_addr;
        dm_wdata = '0;
      end else if (accept && ityp == TYPE_STORE) begin
        dm_we = 1'b1;
      end
    end
  end

  data_mem #(
    .DATA_W   (DATA_W),
    .DM_DEPTH (DM_DEPTH)
  ) u_data_mem (
    .clk   (clk),
    .we    (dm_we),
    .waddr (dm_waddr),
    .wdata (dm_wdata),
    .raddr (addr),
    .rdata (dm_rdata)
  );

  always_ff @(posedge clk) begin
    if (mem_reset) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      rf_we    <= 1'b0;
      wreg     <= 2'd0;
      wdata    <= '0;
      wb_inst  <= INST_W'(NOP_INST);
      retired  <= 8'd0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_addr <= clr_addr + AW'(1);
        if (clr_addr == LAST_ADDR) begin
          state <= ST_RUN;
        end
      end
      if (accept) begin
        rf_we   <= (ityp == TYPE_ALU) || (ityp == TYPE_LOAD);
        wreg    <= in_inst[WREG_HI:WREG_LO];
        wdata   <= (ityp == TYPE_LOAD) ? dm_rdata : in_result;
        wb_inst <= in_inst;
        retired <= retired + 8'd1;
      end else begin
        // Dropped slot becomes a bubble; wreg/wdata are don't-care while rf_we is low.
        rf_we   <= 1'b0;
        wb_inst <= INST_W'(NOP_INST);
      end
    end
  end

`ifdef MEM_WB_BYPASS_EN
  assign fwd_valid = accept && ((ityp == TYPE_ALU) || (ityp == TYPE_LOAD));
  assign fwd_reg   = in_inst[WREG_HI:WREG_LO];
  assign fwd_data  = (ityp == TYPE_LOAD) ? dm_rdata : in_result;
`endif

endmodule
